sa_feeder: RTL and testbench

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_pkg.sv | 15 +
 rtl/sa_feed_fifo.sv | 52 +++++
 rtl/sa_feeder.sv | 159 +++++++++++++++
 tb/tb_sa_feeder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder: FSM encodings and K-counter width.
package sa_pkg;

    localparam int SA_K_MAX = 16;
    localparam int KCNT_W   = $clog2(SA_K_MAX + 1);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_START = 5'b00010,
        S_FEED  = 5'b00100,
        S_FLUSH = 5'b01000,
        S_DONE  = 5'b10000
    } feed_state_e;

endpackage

// File: rtl/sa_feed_fifo.sv
// Small synchronous FIFO holding {X column, W row} beats; head is the oldest entry.
module sa_feed_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             I_CLK,
    input  logic             I_ASYN_RSTN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Guard here too so a caller can never overrun or underrun the pointers.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge I_CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sa_feeder.sv
// Feeds K beats of X columns / W rows from a prefill FIFO into a systolic array,
// then waits for the array result and pulses done plus a one-cycle array clear.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int D_W   = 16,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int K_MAX = 16,
    parameter int DEPTH = 4
) (
    input  logic                 I_CLK,
    input  logic                 I_ASYN_RSTN,
    input  logic                 I_GO,
    input  logic [4:0]           I_CFG_K,
    input  logic                 I_VLD,
    output logic                 O_RDY,
    input  logic [SA_R*D_W-1:0]  I_XCOL,
    input  logic [SA_C*D_W-1:0]  I_WROW,
    input  logic                 I_PE_SHIFT,
    input  logic                 I_OUT_VLD,
    output logic                 O_START_FLAG,
    output logic                 O_SA_SYNC_RSTN,
    output logic [SA_R*D_W-1:0]  O_X,
    output logic [SA_C*D_W-1:0]  O_W,
    output logic                 O_MATSHIFT_OVER,
    output logic                 O_BUSY,
    output logic                 O_DONE,
    output logic                 O_ERR
);
    localparam int XW = SA_R * D_W;
    localparam int WW = SA_C * D_W;
    localparam int FW = XW + WW;

    feed_state_e       state_q, state_d;
    logic [KCNT_W-1:0] k_q, k_d;
    logic [KCNT_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]     x_q, x_d;
    logic [WW-1:0]     w_q, w_d;
    logic              err_q, err_d;

    logic              pop;
    logic              full, empty;
    logic [FW-1:0]     head;
    logic              k_ok;

    sa_feed_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .push_i      (I_VLD),
        .data_i      ({I_XCOL, I_WROW}),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    assign O_RDY           = ~full;
    assign O_X             = x_q;
    assign O_W             = w_q;
    assign O_ERR           = err_q;
    assign O_BUSY          = (state_q != S_IDLE);
    assign O_START_FLAG    = (state_q == S_START);
    assign O_MATSHIFT_OVER = (state_q == S_FLUSH);
    assign O_DONE          = (state_q == S_DONE);
    assign O_SA_SYNC_RSTN  = (state_q != S_DONE);

    assign k_ok = (I_CFG_K != 5'd0) && (int'(I_CFG_K) <= K_MAX);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        w_d     = w_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_GO) begin
                    if (k_ok) begin
                        k_d     = KCNT_W'(I_CFG_K);
                        err_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_START: begin
                if (!empty) begin
                    pop = 1'b1;
                    x_d = head[FW-1:WW];
                    w_d = head[WW-1:0];
                end else begin
                    x_d   = '0;
                    w_d   = '0;
                    err_d = 1'b1;
                end
                cnt_d   = KCNT_W'(1);
                state_d = S_FEED;
            end
            S_FEED: begin
                if (I_PE_SHIFT) begin
                    if (cnt_q < k_q) begin
                        // An underrun still advances the count so the array sees exactly K beats.
                        if (!empty) begin
                            pop = 1'b1;
                            x_d = head[FW-1:WW];
                            w_d = head[WW-1:0];
                        end else begin
                            x_d   = '0;
                            w_d   = '0;
                            err_d = 1'b1;
                        end
                        cnt_d = cnt_q + KCNT_W'(1);
                    end else begin
                        x_d     = '0;
                        w_d     = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                x_d = '0;
                w_d = '0;
                if (I_OUT_VLD) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            w_q     <= w_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder: prefill, feed, flush, underrun, full FIFO, bad K and mid-run reset.
module tb_sa_feeder;

    localparam int D_W   = 16;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int K_MAX = 16;
    localparam int DEPTH = 4;
    localparam int XW    = SA_R * D_W;
    localparam int WW    = SA_C * D_W;

    logic          I_CLK = 1'b0;
    logic          I_ASYN_RSTN;
    logic          I_GO, I_VLD, I_PE_SHIFT, I_OUT_VLD;
    logic [4:0]    I_CFG_K;
    logic [XW-1:0] I_XCOL;
    logic [WW-1:0] I_WROW;
    logic          O_RDY, O_START_FLAG, O_SA_SYNC_RSTN, O_MATSHIFT_OVER;
    logic          O_BUSY, O_DONE, O_ERR;
    logic [XW-1:0] O_X;
    logic [WW-1:0] O_W;

    int checks   = 0;
    int failures = 0;

    sa_feeder #(
        .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .DEPTH(DEPTH)
    ) dut (
        .I_CLK           (I_CLK),
        .I_ASYN_RSTN     (I_ASYN_RSTN),
        .I_GO            (I_GO),
        .I_CFG_K         (I_CFG_K),
        .I_VLD           (I_VLD),
        .O_RDY           (O_RDY),
        .I_XCOL          (I_XCOL),
        .I_WROW          (I_WROW),
        .I_PE_SHIFT      (I_PE_SHIFT),
        .I_OUT_VLD       (I_OUT_VLD),
        .O_START_FLAG    (O_START_FLAG),
        .O_SA_SYNC_RSTN  (O_SA_SYNC_RSTN),
        .O_X             (O_X),
        .O_W             (O_W),
        .O_MATSHIFT_OVER (O_MATSHIFT_OVER),
        .O_BUSY          (O_BUSY),
        .O_DONE          (O_DONE),
        .O_ERR           (O_ERR)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XW-1:0] xv(input int j);
        logic [XW-1:0] r;
        for (int i = 0; i < SA_R; i++) r[i*D_W +: D_W] = D_W'(j + 1);
        return r;
    endfunction

    function automatic logic [WW-1:0] wv(input int j);
        logic [WW-1:0] r;
        for (int i = 0; i < SA_C; i++) r[i*D_W +: D_W] = D_W'(16 + j);
        return r;
    endfunction

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic push(input int j);
        I_VLD  = 1'b1;
        I_XCOL = xv(j);
        I_WROW = wv(j);
        step();
        I_VLD  = 1'b0;
    endtask

    task automatic go(input int k);
        I_GO    = 1'b1;
        I_CFG_K = 5'(k);
        step();
        I_GO    = 1'b0;
    endtask

    task automatic shift();
        I_PE_SHIFT = 1'b1;
        step();
        I_PE_SHIFT = 1'b0;
    endtask

    task automatic finish_result();
        I_OUT_VLD = 1'b1;
        step();
        I_OUT_VLD = 1'b0;
        step();
    endtask

    initial begin
        I_ASYN_RSTN = 1'b0;
        I_GO = 1'b0; I_VLD = 1'b0; I_PE_SHIFT = 1'b0; I_OUT_VLD = 1'b0;
        I_CFG_K = 5'd0; I_XCOL = '0; I_WROW = '0;
        step();
        step();
        check("rst_busy",  256'(O_BUSY), 256'(0));
        check("rst_start", 256'(O_START_FLAG), 256'(0));
        check("rst_done",  256'(O_DONE), 256'(0));
        check("rst_over",  256'(O_MATSHIFT_OVER), 256'(0));
        check("rst_err",   256'(O_ERR), 256'(0));
        check("rst_srst",  256'(O_SA_SYNC_RSTN), 256'(1));
        check("rst_x",     256'(O_X), 256'(0));
        I_ASYN_RSTN = 1'b1;
        step();
        check("rst_rdy",   256'(O_RDY), 256'(1));

        // Nominal K=3 with three prefilled beats.
        push(0); push(1); push(2);
        go(3);
        check("t1_start",   256'(O_START_FLAG), 256'(1));
        check("t1_busy",    256'(O_BUSY), 256'(1));
        check("t1_x_pre",   256'(O_X), 256'(0));
        step();
        check("t1_start_1c", 256'(O_START_FLAG), 256'(0));
        check("t1_x0",      256'(O_X), 256'(xv(0)));
        check("t1_w0",      256'(O_W), 256'(wv(0)));
        step();
        check("t1_x0_hold", 256'(O_X), 256'(xv(0)));
        shift();
        check("t1_x1",      256'(O_X), 256'(xv(1)));
        check("t1_w1",      256'(O_W), 256'(wv(1)));
        shift();
        check("t1_x2",      256'(O_X), 256'(xv(2)));
        check("t1_over_n",  256'(O_MATSHIFT_OVER), 256'(0));
        shift();
        check("t1_x_zero",  256'(O_X), 256'(0));
        check("t1_w_zero",  256'(O_W), 256'(0));
        check("t1_over",    256'(O_MATSHIFT_OVER), 256'(1));
        step();
        check("t1_flush_hold", 256'(O_MATSHIFT_OVER), 256'(1));
        I_OUT_VLD = 1'b1;
        step();
        I_OUT_VLD = 1'b0;
        check("t1_done",    256'(O_DONE), 256'(1));
        check("t1_srst",    256'(O_SA_SYNC_RSTN), 256'(0));
        check("t1_over_d",  256'(O_MATSHIFT_OVER), 256'(0));
        step();
        check("t1_done_1c", 256'(O_DONE), 256'(0));
        check("t1_srst_1c", 256'(O_SA_SYNC_RSTN), 256'(1));
        check("t1_idle",    256'(O_BUSY), 256'(0));
        check("t1_err",     256'(O_ERR), 256'(0));

        // Illegal K values are flagged and do not start a matmul.
        go(0);
        check("t4_k0_err",  256'(O_ERR), 256'(1));
        check("t4_k0_busy", 256'(O_BUSY), 256'(0));
        step();
        check("t4_k0_idle", 256'(O_BUSY), 256'(0));
        go(17);
        check("t4_k17_busy", 256'(O_BUSY), 256'(0));

        // Fill the FIFO; a fifth beat must be refused.
        push(0);
        check("t2_rdy1", 256'(O_RDY), 256'(1));
        push(1); push(2);
        check("t2_rdy3", 256'(O_RDY), 256'(1));
        push(3);
        check("t2_full", 256'(O_RDY), 256'(0));
        push(9);
        check("t2_full_hold", 256'(O_RDY), 256'(0));
        go(4);
        check("t2_err_clr", 256'(O_ERR), 256'(0));
        check("t2_rdy_start", 256'(O_RDY), 256'(0));
        step();
        check("t2_rdy_pop", 256'(O_RDY), 256'(1));
        check("t2_x0",      256'(O_X), 256'(xv(0)));
        // A GO while feeding must not restart or change K.
        go(1);
        check("t4_go_feed_start", 256'(O_START_FLAG), 256'(0));
        check("t4_go_feed_x",     256'(O_X), 256'(xv(0)));
        shift();
        check("t2_x1",      256'(O_X), 256'(xv(1)));
        shift();
        check("t2_x2",      256'(O_X), 256'(xv(2)));
        shift();
        check("t2_x3",      256'(O_X), 256'(xv(3)));
        check("t2_over_n",  256'(O_MATSHIFT_OVER), 256'(0));
        shift();
        check("t2_over",    256'(O_MATSHIFT_OVER), 256'(1));
        check("t2_err",     256'(O_ERR), 256'(0));
        finish_result();
        // The FIFO must now be empty: a K=1 run underruns.
        go(1);
        step();
        check("t2_empty_x",   256'(O_X), 256'(0));
        check("t2_empty_err", 256'(O_ERR), 256'(1));
        shift();
        finish_result();

        // K=2 with a single beat supplied.
        push(5);
        go(2);
        check("t3_err_clr", 256'(O_ERR), 256'(0));
        step();
        check("t3_x5",      256'(O_X), 256'(xv(5)));
        check("t3_w5",      256'(O_W), 256'(wv(5)));
        shift();
        check("t3_x_zero",  256'(O_X), 256'(0));
        check("t3_err",     256'(O_ERR), 256'(1));
        check("t3_over_n",  256'(O_MATSHIFT_OVER), 256'(0));
        shift();
        check("t3_over",    256'(O_MATSHIFT_OVER), 256'(1));
        I_OUT_VLD = 1'b1;
        step();
        I_OUT_VLD = 1'b0;
        check("t3_done",    256'(O_DONE), 256'(1));
        step();
        check("t3_err_sticky", 256'(O_ERR), 256'(1));
        check("t3_idle",    256'(O_BUSY), 256'(0));

        // Reset in FEED with two beats still queued.
        push(6); push(7); push(8);
        go(2);
        step();
        check("t5_x6",      256'(O_X), 256'(xv(6)));
        I_ASYN_RSTN = 1'b0;
        #1;
        check("t5_busy",    256'(O_BUSY), 256'(0));
        check("t5_x",       256'(O_X), 256'(0));
        check("t5_w",       256'(O_W), 256'(0));
        check("t5_err",     256'(O_ERR), 256'(0));
        check("t5_srst",    256'(O_SA_SYNC_RSTN), 256'(1));
        step();
        I_ASYN_RSTN = 1'b1;
        step();
        check("t5_rdy",     256'(O_RDY), 256'(1));
        go(1);
        step();
        check("t5_empty_x",   256'(O_X), 256'(0));
        check("t5_empty_err", 256'(O_ERR), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
